// File: rtl/lcd_pkg.sv
// Shared opcodes, HD44780 init bytes, DDRAM line geometry and FSM state types
// for the LCD command executor and its bus writer.
package lcd_pkg;

    localparam logic [3:0] OP_CLEAR = 4'b0000;
    localparam logic [3:0] OP_WRITE = 4'b0001;
    localparam logic [3:0] OP_SETAD = 4'b0011;
    localparam logic [3:0] OP_WAIT2 = 4'b0100;

    localparam logic [7:0] INIT_FUNC  = 8'h38;
    localparam logic [7:0] INIT_DISP  = 8'h0C;
    localparam logic [7:0] INIT_ENTRY = 8'h06;
    localparam logic [7:0] INIT_CLEAR = 8'h01;

    localparam logic [7:0] LINE2_BASE = 8'h40;
    localparam logic [7:0] LINE_WIDTH = 8'd40;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_BUS,
        ST_DELAY
    } lcd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } wr_state_t;

    function automatic logic [7:0] init_byte(input logic [1:0] step);
        case (step)
            2'd0:    return INIT_FUNC;
            2'd1:    return INIT_DISP;
            2'd2:    return INIT_ENTRY;
            default: return INIT_CLEAR;
        endcase
    endfunction

    // Linear column index -> "set DDRAM address" instruction; line 2 starts at 0x40.
    function automatic logic [7:0] setad_byte(input logic [7:0] arg);
        logic [7:0] addr;
        if (arg < LINE_WIDTH)
            addr = arg;
        else
            addr = LINE2_BASE + (arg - LINE_WIDTH);
        return {1'b1, addr[6:0]};
    endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// One HD44780 write: latch RS/DB, E low for SETUP_CYC, high for E_HIGH_CYC, then wait.
// start is only accepted while idle; done pulses for one cycle in the last wait cycle.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC      = 4,
    parameter int unsigned E_HIGH_CYC     = 25,
    parameter int unsigned CMD_WAIT_CYC   = 2000,
    parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data_byte,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       lcd_en
);

    localparam int unsigned MAX_A = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int unsigned MAX_B = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = $clog2(MAX_C + 1);

    wr_state_t      state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           long_q, long_nxt;
    logic           rs_nxt, en_nxt;
    logic [7:0]     data_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WR_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            lcd_en   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            long_q   <= long_nxt;
            lcd_rs   <= rs_nxt;
            lcd_data <= data_nxt;
            lcd_en   <= en_nxt;
        end
    end

    // Counters are loaded with N-1 so each phase lasts exactly N cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        long_nxt  = long_q;
        rs_nxt    = lcd_rs;
        data_nxt  = lcd_data;
        en_nxt    = lcd_en;
        done      = 1'b0;
        case (state)
            WR_IDLE: begin
                if (start) begin
                    state_nxt = WR_SETUP;
                    cnt_nxt   = CW'(SETUP_CYC - 1);
                    rs_nxt    = rs;
                    data_nxt  = data_byte;
                    long_nxt  = long_wait;
                end
            end
            WR_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = WR_PULSE;
                    cnt_nxt   = CW'(E_HIGH_CYC - 1);
                    en_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WR_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = WR_HOLD;
                    cnt_nxt   = long_q ? CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
                    en_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WR_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = WR_IDLE;
                    done      = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = WR_IDLE;
        endcase
    end

endmodule

// File: rtl/lcd_cmd_exec.sv
// Powers up and initialises an HD44780 panel, then walks the command table by index.
// Table fetch adds 2 cycles per entry; the walk stalls while a bus write or wait2 runs.
module lcd_cmd_exec
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned SETUP_CYC      = 4,
    parameter int unsigned E_HIGH_CYC     = 25,
    parameter int unsigned CMD_WAIT_CYC   = 2000,
    parameter int unsigned CLEAR_WAIT_CYC = 82000,
    parameter int unsigned WAIT2_CYC      = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] cmd_idx,
    input  logic [11:0] cmd_data,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        LCD_ON,
    output logic        init_done
);

    localparam int unsigned TOP_MAX = (POWERUP_CYC > WAIT2_CYC) ? POWERUP_CYC : WAIT2_CYC;
    localparam int unsigned CW      = $clog2(TOP_MAX + 1);

    lcd_state_t     state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [1:0]     step, step_nxt;
    logic [31:0]    idx_nxt;
    logic [11:0]    word, word_nxt;
    logic           done_nxt;

    logic           wr_start, wr_rs, wr_long, wr_done;
    logic [7:0]     wr_byte;

    wire [3:0] op  = word[11:8];
    wire [7:0] arg = word[7:0];

    assign LCD_RW = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_PWRUP;
            cnt       <= CW'(POWERUP_CYC);
            step      <= 2'd0;
            cmd_idx   <= 32'd0;
            word      <= 12'h000;
            init_done <= 1'b0;
            LCD_ON    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            step      <= step_nxt;
            cmd_idx   <= idx_nxt;
            word      <= word_nxt;
            init_done <= done_nxt;
            LCD_ON    <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_nxt  = step;
        idx_nxt   = cmd_idx;
        word_nxt  = word;
        done_nxt  = init_done;
        wr_start  = 1'b0;
        wr_rs     = 1'b0;
        wr_byte   = 8'h00;
        wr_long   = 1'b0;
        case (state)
            ST_PWRUP: begin
                if (cnt == '0) begin
                    state_nxt = ST_INIT;
                    step_nxt  = 2'd0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_INIT: begin
                wr_start  = 1'b1;
                wr_byte   = init_byte(step);
                wr_long   = (step == 2'd3);
                state_nxt = ST_BUS;
            end
            ST_FETCH: begin
                word_nxt  = cmd_data;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                case (op)
                    OP_WRITE: begin
                        wr_start  = 1'b1;
                        wr_rs     = 1'b1;
                        wr_byte   = arg;
                        state_nxt = ST_BUS;
                    end
                    OP_SETAD: begin
                        wr_start  = 1'b1;
                        wr_byte   = setad_byte(arg);
                        state_nxt = ST_BUS;
                    end
                    OP_CLEAR: begin
                        wr_start  = 1'b1;
                        wr_byte   = INIT_CLEAR;
                        wr_long   = 1'b1;
                        state_nxt = ST_BUS;
                    end
                    OP_WAIT2: begin
                        cnt_nxt   = CW'(WAIT2_CYC - 1);
                        state_nxt = ST_DELAY;
                    end
                    default: begin
                        idx_nxt   = cmd_idx + 32'd1;
                        state_nxt = ST_FETCH;
                    end
                endcase
            end
            ST_DELAY: begin
                if (cnt == '0) begin
                    idx_nxt   = cmd_idx + 32'd1;
                    state_nxt = ST_FETCH;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_BUS: begin
                // init_done low means the write in flight belongs to the init sequence.
                if (wr_done) begin
                    if (!init_done) begin
                        if (step == 2'd3) begin
                            done_nxt  = 1'b1;
                            idx_nxt   = 32'd0;
                            state_nxt = ST_FETCH;
                        end else begin
                            step_nxt  = step + 2'd1;
                            state_nxt = ST_INIT;
                        end
                    end else begin
                        idx_nxt   = (op == OP_CLEAR) ? 32'd0 : cmd_idx + 32'd1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            default: state_nxt = ST_PWRUP;
        endcase
    end

    lcd_bus_writer #(
        .SETUP_CYC      (SETUP_CYC),
        .E_HIGH_CYC     (E_HIGH_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) u_bus_writer (
        .clk       (clk),
        .rst       (rst),
        .start     (wr_start),
        .rs        (wr_rs),
        .data_byte (wr_byte),
        .long_wait (wr_long),
        .done      (wr_done),
        .lcd_rs    (LCD_RS),
        .lcd_data  (LCD_DATA),
        .lcd_en    (LCD_EN)
    );

endmodule

// File: doc/lcd_cmd_exec.md
# lcd_cmd_exec

Executes the 12-bit LCD command stream produced by the `LCD_command` table and drives the HD44780-compatible character LCD pins. It powers up and initialises the panel, then walks the table by index. Each `{op[3:0], arg[7:0]}` word becomes a bus write, an address set, a timed pause, or a clear-and-restart. It sits between the command table (combinational, index → word) and the board LCD pins.

## Interface
- `POWERUP_CYC`, 750000: cycles idle after reset before the first init write (15 ms @ 50 MHz).
- `SETUP_CYC`, 4: cycles RS/DB are stable with E low before E rises.
- `E_HIGH_CYC`, 25: cycles E held high.
- `CMD_WAIT_CYC`, 2000: cycles after E falls for a normal instruction or data write (40 µs).
- `CLEAR_WAIT_CYC`, 82000: cycles after E falls for a clear (0x01) write (1.64 ms).
- `WAIT2_CYC`, 100000000: pause length for op `wait2` (2 s).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_idx` out 32: index presented to the command table; drives its `_i` input.
- `cmd_data` in 12: table word for `cmd_idx`; drives from its `DATA` output.
- `LCD_DATA` out 8: DB7..DB0.
- `LCD_RS` out 1: 0 = instruction, 1 = data.
- `LCD_RW` out 1: tied 0; the block is write-only.
- `LCD_EN` out 1: enable strobe.
- `LCD_ON` out 1: panel power; 0 in reset, 1 otherwise.
- `init_done` out 1: 1 once the init sequence completes; cleared only by `rst`.

## Operation
- Opcodes (shared package): `clear`=4'b0000, `write`=4'b0001, `setad`=4'b0011, `wait2`=4'b0100.
- States: PWRUP → INIT → FETCH → DECODE → SETUP → PULSE → HOLD → (FETCH | INIT | PWRUP-free loop). `wait2` goes DECODE → DELAY → FETCH.
- PWRUP: count `POWERUP_CYC`, then go to INIT.
- INIT: issue 0x38, 0x0C, 0x06, 0x01 in order, all with RS=0. Each write uses SETUP → PULSE → HOLD. After 0x01, set `init_done` and set `cmd_idx`=0.
- FETCH: `cmd_idx` is stable for one cycle. DECODE registers `cmd_data` on the following edge.
- `write`: RS=1, DB=arg. Then `cmd_idx`+1.
- `setad`: RS=0, DB=0x80 | ddram.
  - arg<40 → ddram=arg (line 1).
  - arg≥40 → ddram=0x40+(arg−40) (line 2).
  - Result is truncated to 7 bits.
  - Then `cmd_idx`+1.
- `clear`: RS=0, DB=0x01, hold for `CLEAR_WAIT_CYC`. Then `cmd_idx`=0; the program restarts.
- `wait2`: no bus activity; E stays low. Count `WAIT2_CYC`, then `cmd_idx`+1.
- Any other opcode: no bus activity. `cmd_idx`+1 on the next cycle.
- `cmd_idx` is 32-bit and wraps from 0xFFFFFFFF to 0. The table's default entry (`clear`) bounds this in practice.
- One shared down-counter, wide enough for the largest parameter (`$clog2`). It is loaded on each state entry; the state exits when the counter reaches 0.

## Timing
- Reset values:
  - `cmd_idx`=0, `LCD_DATA`=0, `LCD_RS`=0, `LCD_RW`=0, `LCD_EN`=0, `LCD_ON`=0, `init_done`=0.
  - State = PWRUP, counter = `POWERUP_CYC`.
- An asserted `rst` mid-operation drops `LCD_EN` immediately (asynchronously) and restarts from PWRUP.
- RS/DB change only in the cycle that enters SETUP. They are held through PULSE and HOLD, giving hold ≥ `CMD_WAIT_CYC` after E falls.
- Per write: SETUP `SETUP_CYC` cycles E low, then `E_HIGH_CYC` cycles E high, then the wait count.
- Fetch latency: 2 cycles (FETCH, DECODE) from a `cmd_idx` change to SETUP entry.
- E never rises outside PULSE. There is exactly one E pulse per LCD write.

## Structure
- Package `lcd_pkg` holds:
  - the opcode constants;
  - the init instruction constants 0x38/0x0C/0x06/0x01;
  - the line-2 base 0x40 and line width 40;
  - the state enum.
- One natural sub-module: `lcd_bus_writer`. Inputs are rs, byte, long_wait, start; output is done. It owns SETUP/PULSE/HOLD and the wait counter. The top-level FSM handles init, fetch, decode and `wait2`.

## Test plan
Bench parameters: `POWERUP_CYC`=10, `SETUP_CYC`=1, `E_HIGH_CYC`=2, `CMD_WAIT_CYC`=4, `CLEAR_WAIT_CYC`=8, `WAIT2_CYC`=20. The bench drives `cmd_data` from a model of the command table.

- Reset, then release → no E edge for 10 cycles. Then four E pulses with RS=0 and DB 0x38, 0x0C, 0x06, 0x01; `init_done`=1 after the 0x01 wait.
- Table entry 0 = `{setad,8'd04}` → DB=0x84, RS=0. Entry 9 = `{setad,8'd43}` → DB=0xC3, RS=0.
- Entry 1 = `{write,"W"}` → RS=1, DB=0x57. The E high width is exactly 2 cycles, RS/DB are stable 1 cycle before E rises, and `cmd_idx` goes 1→2.
- Entry 20 = `wait2` → E stays low for 20 cycles, then `cmd_idx`=21. Entry 21 = `clear` → DB=0x01 pulse, 8-cycle wait, then `cmd_idx`=0.
- Opcode 4'b1111 → no E pulse; `cmd_idx` increments.
- `rst` asserted while E is high → `LCD_EN`=0 within the same cycle, all outputs return to reset values, and the init sequence replays.
